// File: rtl/iir1_multichannel_filter.sv
// First-order IIR (high-pass / low-pass / bypass) over a packed multichannel frame,
// one shared multiplier stepping through the channels, CHANNELS+1 cycles strobe to out_valid.
module iir1_multichannel_filter #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int COEF_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [CHANNELS*DATA_W-1:0]   data_in,
  input  logic [1:0]                   mode,
  input  logic [COEF_W-1:0]            coef,
  output logic [CHANNELS*DATA_W-1:0]   data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int S_W  = DATA_W + 2;
  localparam int P_W  = S_W + COEF_W + 1;
  localparam int R_W  = DATA_W + 3;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                       state_q, state_d;
  logic [CH_W-1:0]              ch_q;
  logic [CHANNELS*DATA_W-1:0]   frame_q;
  logic [1:0]                   mode_q;
  logic [COEF_W-1:0]            coef_q;
  logic signed [DATA_W-1:0]     x_prev_q [CHANNELS];
  logic signed [DATA_W-1:0]     y_prev_q [CHANNELS];
  logic signed [DATA_W-1:0]     shadow_q [CHANNELS];
  logic [CHANNELS*DATA_W-1:0]   data_out_q;
  logic                         out_valid_q;
  logic                         overrun_q;

  logic                         last_ch, accept, step, finish, drop;
  logic signed [DATA_W-1:0]     x_arr [CHANNELS];
  logic signed [DATA_W-1:0]     x_cur, xp_cur, yp_cur, y_cur;
  logic signed [S_W-1:0]        s_op;
  logic signed [R_W-1:0]        add_op, r_mul, r_val;
  logic signed [P_W-1:0]        prod;

  assign last_ch = (ch_q == LAST_CH);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = CALC;
      CALC:    if (last_ch)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && sample_valid;
    step   = (state_q == CALC);
    finish = (state_q == CALC) && last_ch;
    drop   = (state_q == CALC) && sample_valid;
    busy   = (state_q == CALC);
  end

  // Channel 0 sits in the MSBs of the packed frame.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      x_arr[k] = frame_q[(CHANNELS-k)*DATA_W-1 -: DATA_W];
  end

  assign x_cur  = x_arr[ch_q];
  assign xp_cur = x_prev_q[ch_q];
  assign yp_cur = y_prev_q[ch_q];

  // Operand select feeding the single multiplier; LPF adds x back after scaling.
  always_comb begin
    s_op   = '0;
    add_op = '0;
    case (mode_q)
      2'b01: s_op = S_W'(yp_cur) + S_W'(x_cur) - S_W'(xp_cur);
      2'b10: begin
        s_op   = S_W'(yp_cur) - S_W'(x_cur);
        add_op = R_W'(x_cur);
      end
      default: s_op = '0;
    endcase
  end

  assign prod  = P_W'(s_op) * P_W'($signed({1'b0, coef_q}));
  assign r_mul = R_W'(prod >>> COEF_W);

  always_comb begin
    if (mode_q == 2'b01 || mode_q == 2'b10) r_val = r_mul + add_op;
    else                                    r_val = R_W'(x_cur);
    if (r_val[R_W-1:DATA_W-1] != {(R_W-DATA_W+1){r_val[R_W-1]}})
      y_cur = r_val[R_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      y_cur = r_val[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      frame_q     <= '0;
      mode_q      <= '0;
      coef_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        x_prev_q[k] <= '0;
        y_prev_q[k] <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      out_valid_q <= finish;
      overrun_q   <= drop;
      if (accept) begin
        frame_q <= data_in;
        mode_q  <= mode;
        coef_q  <= coef;
        ch_q    <= '0;
      end
      if (step) begin
        x_prev_q[ch_q] <= x_cur;
        y_prev_q[ch_q] <= y_cur;
        shadow_q[ch_q] <= y_cur;
        ch_q           <= last_ch ? '0 : ch_q + 1'b1;
      end
      // The last channel's result bypasses the shadow slot it is being written into.
      if (finish) begin
        for (int k = 0; k < CHANNELS; k++)
          data_out_q[(CHANNELS-k)*DATA_W-1 -: DATA_W] <= (CH_W'(k) == ch_q) ? y_cur : shadow_q[k];
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_iir1_multichannel_filter.sv
// Self-checking bench for iir1_multichannel_filter: directed scenarios plus random
// frames against an integer-arithmetic reference of the filter equations.
module tb_iir1_multichannel_filter;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int CW = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid;
  logic [CH*DW-1:0]   data_in;
  logic [1:0]         mode;
  logic [CW-1:0]      coef;
  logic [CH*DW-1:0]   data_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int n_cmp = 0;
  int n_err = 0;
  int mx [CH];
  int my [CH];

  iir1_multichannel_filter #(.DATA_W(DW), .CHANNELS(CH), .COEF_W(CW)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .data_in(data_in),
    .mode(mode), .coef(coef), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int out_ch(input int k);
    logic signed [DW-1:0] v;
    v = data_out[(CH-k)*DW-1 -: DW];
    return int'(v);
  endfunction

  // Reference: y = sat(r) with r from the first-order difference equations, floor scaling.
  function automatic int model_step(input int k, input int x, input int md, input int cf);
    longint s, r;
    case (md)
      1: begin s = longint'(my[k]) + x - mx[k]; r = (s * cf) >>> CW; end
      2: begin s = longint'(my[k]) - x;         r = x + ((s * cf) >>> CW); end
      default: r = x;
    endcase
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    mx[k] = x;
    my[k] = int'(r);
    return int'(r);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < CH; k++) begin mx[k] = 0; my[k] = 0; end
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_clear();
  endtask

  // Sends a frame in the current cycle and waits for its result; returns in the out_valid cycle.
  task automatic send_frame(input string nm, input int v0, input int v1, input logic [1:0] md,
                            input logic [CW-1:0] cf, input bit wiggle, output int o0, output int o1);
    int e0, e1, cnt;
    logic signed [DW-1:0] t0, t1;
    t0 = v0[DW-1:0]; t1 = v1[DW-1:0];
    data_in = {t0, t1}; mode = md; coef = cf; sample_valid = 1'b1;
    e0 = model_step(0, int'(t0), int'(md), int'(cf));
    e1 = model_step(1, int'(t1), int'(md), int'(cf));
    tick();
    sample_valid = 1'b0;
    check({nm, " busy"}, int'(busy), 1);
    check({nm, " no_double_valid"}, int'(out_valid), 0);
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 20) begin
      if (wiggle) begin mode = 2'($urandom); coef = CW'($urandom); end
      tick();
      cnt++;
    end
    check({nm, " latency"}, cnt, CH + 1);
    check({nm, " busy_done"}, int'(busy), 0);
    o0 = out_ch(0); o1 = out_ch(1);
    check({nm, " ch0"}, o0, e0);
    check({nm, " ch1"}, o1, e1);
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b1; data_in = '1; mode = 2'b01; coef = 16'hC000;
    tick();
    reset = 1'b0; sample_valid = 1'b0;
    model_clear();
    check("reset data_out", int'(data_out), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    tick();
    check("reset_wins busy", int'(busy), 0);
  endtask

  task automatic test_hpf_step();
    int o0, o1;
    int exp_v [3] = '{750, 562, 421};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame("hpf", 1000, 1000, 2'b01, 16'hC000, 1'b0, o0, o1);
      check("hpf const ch0", o0, exp_v[i]);
      check("hpf const ch1", o1, exp_v[i]);
    end
  endtask

  task automatic test_lpf_step();
    int o0, o1;
    do_reset();
    send_frame("lpf", 1000, -1000, 2'b10, 16'hC000, 1'b0, o0, o1);
    check("lpf const ch0 f1", o0, 250);
    check("lpf const ch1 f1", o1, -250);
    send_frame("lpf", 1000, -1000, 2'b10, 16'hC000, 1'b0, o0, o1);
    check("lpf const ch0 f2", o0, 437);
  endtask

  task automatic test_saturation();
    int o0, o1;
    do_reset();
    send_frame("sat", -32768, 0, 2'b01, 16'hFFFF, 1'b0, o0, o1);
    check("sat f1 ch0", o0, -32768);
    send_frame("sat", 32767, 0, 2'b01, 16'hFFFF, 1'b0, o0, o1);
    send_frame("sat", -32768, 0, 2'b01, 16'hFFFF, 1'b0, o0, o1);
    check("sat clip_low ch0", o0, -32768);
    send_frame("sat", 32767, 0, 2'b01, 16'hFFFF, 1'b0, o0, o1);
    send_frame("sat", 32767, 32767, 2'b10, 16'hFFFF, 1'b0, o0, o1);
  endtask

  task automatic test_bypass_switch();
    int o0, o1;
    do_reset();
    send_frame("byp", 500, -7, 2'b00, 16'h1234, 1'b0, o0, o1);
    check("byp const ch0", o0, 500);
    check("byp const ch1", o1, -7);
    send_frame("byp2lpf", 500, -7, 2'b10, 16'hC000, 1'b0, o0, o1);
    check("byp2lpf const ch0", o0, 500);
    check("byp2lpf const ch1", o1, -7);
  endtask

  task automatic test_overrun();
    int e0, e1, nv;
    do_reset();
    data_in = {16'sd1000, 16'sd1000}; mode = 2'b01; coef = 16'hC000; sample_valid = 1'b1;
    e0 = model_step(0, 1000, 1, 16'hC000);
    e1 = model_step(1, 1000, 1, 16'hC000);
    tick();
    data_in = {16'sd3000, -16'sd3000}; mode = 2'b10; coef = 16'h4000;
    check("ovr T+1 overrun", int'(overrun), 0);
    tick();
    sample_valid = 1'b0;
    check("ovr T+2 overrun", int'(overrun), 1);
    nv = 0;
    tick();
    check("ovr T+3 overrun", int'(overrun), 0);
    check("ovr T+3 out_valid", int'(out_valid), 1);
    check("ovr latched ch0", out_ch(0), e0);
    check("ovr latched ch1", out_ch(1), e1);
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) nv++;
      tick();
    end
    check("ovr single out_valid", nv, 1);
  endtask

  task automatic test_reset_midframe();
    int o0, o1, nv;
    send_frame("pre", 1234, -4321, 2'b00, 16'h0, 1'b0, o0, o1);
    data_in = {16'sd1000, 16'sd1000}; mode = 2'b01; coef = 16'hC000; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check("rstmid data_out", int'(data_out), 0);
    check("rstmid busy", int'(busy), 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid === 1'b1) nv++;
      tick();
    end
    check("rstmid no out_valid", nv, 0);
    send_frame("rstmid hpf", 1000, 1000, 2'b01, 16'hC000, 1'b0, o0, o1);
    check("rstmid const ch0", o0, 750);
  endtask

  task automatic test_back_to_back_random();
    int o0, o1;
    do_reset();
    for (int i = 0; i < 60; i++)
      send_frame("rand", int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 2'($urandom), CW'($urandom), 1'b1, o0, o1);
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; data_in = '0; mode = '0; coef = '0;
    test_reset();
    test_hpf_step();
    test_lpf_step();
    test_saturation();
    test_bypass_switch();
    test_overrun();
    test_reset_midframe();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
